// File: rtl/pulse_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_gen_pkg : shared state encoding and timing helper for          |
// |                 multi_pulse_gen                                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  function automatic int us_to_ticks(input int clk_mhz, input int us);
    return clk_mhz * us;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : WIDTH-bit two-flop synchroniser with per-bit reset level  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/multi_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_pulse_gen : N_CH staggered active-low pulse trains, periodic   |
// |                   or one-shot, with runt-free graceful stop          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multi_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CLK_MHZ    = 24,
  parameter int N_CH       = 4,
  parameter int PERIOD_US  = 25_000,
  parameter int WIDTH_US   = 50,
  parameter int STAGGER_US = 1_000
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            init,
  input  logic            pulse_disable,
  input  logic            mode,
  input  logic            trig_n,
  output logic [N_CH-1:0] pulse_out,
  output logic            busy,
  output logic            period_done
);

  localparam int PERIOD_TICKS  = us_to_ticks(CLK_MHZ, PERIOD_US);
  localparam int WIDTH_TICKS   = us_to_ticks(CLK_MHZ, WIDTH_US);
  localparam int STAGGER_TICKS = us_to_ticks(CLK_MHZ, STAGGER_US);
  localparam int CW            = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(PERIOD_TICKS - 1);

  if ((N_CH < 1) || (N_CH > 16)) begin : g_bad_nch
    $error("multi_pulse_gen: N_CH must lie in 1..16");
  end
  if (WIDTH_TICKS < 1) begin : g_bad_width
    $error("multi_pulse_gen: WIDTH_TICKS must be at least 1");
  end
  if (((N_CH - 1) * STAGGER_TICKS + WIDTH_TICKS) > PERIOD_TICKS) begin : g_bad_fit
    $error("multi_pulse_gen: staggered pulses do not fit in one period");
  end

  logic [2:0]      w_sync_s;
  logic            w_init_s;
  logic            w_dis_s;
  logic            w_trig_s;
  logic            w_trig_fall;
  logic            w_start;
  logic            w_stop_req;
  logic            w_cnt_last;
  logic [CW-1:0]   w_cnt_inc;
  logic [N_CH-1:0] w_in_win;
  logic [N_CH-1:0] w_pulse_nxt;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N_CH-1:0] r_pulse;
  logic            r_busy;
  logic            r_done;
  logic            r_oneshot;
  logic            r_trig_d;

  sync_2ff #(
    .WIDTH   (3),
    .RST_VAL (3'b101)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .i_d   ({init, pulse_disable, trig_n}),
    .o_q   (w_sync_s)
  );

  assign w_init_s    = w_sync_s[2];
  assign w_dis_s     = w_sync_s[1];
  assign w_trig_s    = w_sync_s[0];
  assign w_trig_fall = r_trig_d & ~w_trig_s;
  assign w_start     = ~w_dis_s & ((~mode & ~w_init_s) | (mode & w_trig_fall));
  assign w_stop_req  = w_dis_s | (~r_oneshot & w_init_s);
  assign w_cnt_last  = (r_cnt == C_CNT_LAST);
  assign w_cnt_inc   = w_cnt_last ? '0 : r_cnt + CW'(1);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [31:0] C_START = 32'(k * STAGGER_TICKS);
    localparam logic [31:0] C_END   = 32'(k * STAGGER_TICKS + WIDTH_TICKS);
    if (k == 0) begin : g_first
      assign w_in_win[k] = (32'(r_cnt) < C_END);
    end else begin : g_rest
      assign w_in_win[k] = (32'(r_cnt) >= C_START) && (32'(r_cnt) < C_END);
    end
  end

  // While stopping, a channel may only stay low, never newly fall.
  always_comb begin
    w_pulse_nxt = '1;
    case (r_state)
      ST_RUN:  w_pulse_nxt = ~w_in_win;
      ST_STOP: w_pulse_nxt = r_pulse | ~w_in_win;
      default: w_pulse_nxt = '1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pulse   <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_oneshot <= 1'b0;
      r_trig_d  <= 1'b1;
    end else begin
      r_pulse  <= w_pulse_nxt;
      r_done   <= 1'b0;
      r_trig_d <= w_trig_s;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_start) begin
            r_state   <= ST_RUN;
            r_busy    <= 1'b1;
            r_oneshot <= mode;
          end
        end
        ST_RUN: begin
          r_cnt  <= w_cnt_inc;
          r_done <= w_cnt_last;
          if (w_stop_req) begin
            r_state <= ST_STOP;
          end else if (r_oneshot && w_cnt_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_STOP: begin
          if (&w_pulse_nxt) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign pulse_out   = r_pulse;
  assign busy        = r_busy;
  assign period_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_multi_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_pulse_gen : directed + random bench with behavioural model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_multi_pulse_gen;

  localparam int P = 20;
  localparam int W = 3;
  localparam int S = 5;
  localparam int NCH = 3;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic           init;
  logic           pulse_disable;
  logic           mode;
  logic           trig_n;
  logic [NCH-1:0] pulse_out;
  logic           busy;
  logic           period_done;

  int checks   = 0;
  int failures = 0;

  multi_pulse_gen #(
    .CLK_MHZ    (1),
    .N_CH       (NCH),
    .PERIOD_US  (P),
    .WIDTH_US   (W),
    .STAGGER_US (S)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .init          (init),
    .pulse_disable (pulse_disable),
    .mode          (mode),
    .trig_n        (trig_n),
    .pulse_out     (pulse_out),
    .busy          (busy),
    .period_done   (period_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural model: time since train start, two-sample input delay.
  int       m_n = 0;
  int       m_start = 0;
  bit       m_run, m_stop, m_one, m_done;
  bit [2:0] m_low;
  bit       hi1, hi2, hd1, hd2, ht1, ht2, ht3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_one = 0; m_done = 0; m_low = '0;
    hi1 = 1; hi2 = 1; hd1 = 0; hd2 = 0; ht1 = 1; ht2 = 1; ht3 = 1;
  endtask

  task automatic model_edge();
    int ph;
    bit fall;
    m_n++;
    ph   = (m_run || m_stop) ? ((m_n - m_start) % P) : 0;
    fall = ht3 && !ht2;
    for (int k = 0; k < NCH; k++) begin
      bit inwin;
      inwin = (ph >= k * S) && (ph < k * S + W);
      if (m_run)       m_low[k] = inwin;
      else if (m_stop) m_low[k] = m_low[k] && inwin;
      else             m_low[k] = 1'b0;
    end
    m_done = m_run && (ph == P - 1);
    if (!m_run && !m_stop) begin
      if (!hd2 && ((!mode && !hi2) || (mode && fall))) begin
        m_run = 1; m_one = mode; m_start = m_n + 1;
      end
    end else if (m_run) begin
      if (hd2 || (!m_one && hi2)) begin
        m_run = 0; m_stop = 1;
      end else if (m_one && ph == P - 1) begin
        m_run = 0;
      end
    end else if (m_low == 3'b000) begin
      m_stop = 0;
    end
    ht3 = ht2; ht2 = ht1; ht1 = trig_n;
    hi2 = hi1; hi1 = init;
    hd2 = hd1; hd1 = pulse_disable;
  endtask

  task automatic step();
    logic [2:0] exp_p;
    @(posedge sys_clk);
    model_edge();
    #1;
    exp_p = ~m_low;
    check("pulse_out", pulse_out, exp_p);
    check("busy", busy, m_run || m_stop);
    check("period_done", period_done, m_done);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && (m_run || m_stop); i++) step();
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_phase(input int ph);
    int i;
    for (i = 0; i < 80; i++) begin
      if (m_run && ((m_n + 1 - m_start) % P) == ph) break;
      step();
    end
    check("phase_timeout", (i < 80), 1'b1);
  endtask

  initial begin
    int ch1_low, done_cnt;
    bit ch2_fell;
    logic [2:0] prev;
    int falls[NCH];

    sys_rst_n = 0; init = 1; pulse_disable = 0; mode = 0; trig_n = 1;
    model_reset();
    #12;
    check("reset_pulse", pulse_out, 3'b111);
    check("reset_busy", busy, 1'b0);
    check("reset_done", period_done, 1'b0);
    #10 sys_rst_n = 1;
    repeat (3) step();

    // Periodic: 3-edge start latency and 20-cycle cadence.
    init = 0;
    repeat (3) step();
    check("latency_early", pulse_out[0], 1'b1);
    step();
    check("latency", pulse_out[0], 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (period_done) done_cnt++;
    end
    check("done_count", done_cnt, 3);
    init = 1;
    wait_idle();

    // Disable while ch1 is low at cnt 6.
    init = 0;
    wait_phase(4);
    pulse_disable = 1;
    ch1_low = 0; ch2_fell = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!pulse_out[1]) ch1_low++;
      if (!pulse_out[2]) ch2_fell = 1;
    end
    check("stop_ch1_width", ch1_low, W);
    check("stop_ch2_quiet", ch2_fell, 1'b0);
    check("stop_busy", busy, 1'b0);
    init = 1; pulse_disable = 0;
    repeat (4) step();

    // One-shot with a second trigger during the train.
    mode = 1; trig_n = 0;
    step();
    trig_n = 1;
    foreach (falls[k]) falls[k] = 0;
    done_cnt = 0;
    prev = pulse_out;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) trig_n = 0;
      if (i == 11) trig_n = 1;
      step();
      for (int k = 0; k < NCH; k++) if (prev[k] && !pulse_out[k]) falls[k]++;
      if (period_done) done_cnt++;
      prev = pulse_out;
    end
    for (int k = 0; k < NCH; k++) check("oneshot_falls", falls[k], 1);
    check("oneshot_done", done_cnt, 1);
    check("oneshot_idle", busy, 1'b0);
    mode = 0;

    // Reset asserted mid-pulse at cnt 1.
    init = 0;
    wait_phase(1);
    check("pre_reset_low", pulse_out[0], 1'b0);
    #2 sys_rst_n = 0;
    #1;
    check("async_reset_pulse", pulse_out, 3'b111);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_done", period_done, 1'b0);
    model_reset();
    repeat (2) begin
      @(posedge sys_clk); #1;
      check("held_reset_pulse", pulse_out, 3'b111);
    end
    #3 sys_rst_n = 1;
    repeat (30) step();
    init = 1;
    wait_idle();

    // init and disable asserted together: no start.
    init = 0; pulse_disable = 1;
    repeat (10) step();
    check("init_dis_busy", busy, 1'b0);
    init = 1; pulse_disable = 0;
    repeat (3) step();

    // Random levels and trigger activity.
    for (int it = 0; it < 14; it++) begin
      int hold;
      mode          = 1'($urandom % 2);
      init          = 1'($urandom % 2);
      pulse_disable = 1'(($urandom % 4) == 0);
      hold          = $urandom_range(1, 30);
      for (int j = 0; j < hold; j++) begin
        trig_n = 1'(($urandom % 5) != 0);
        step();
      end
    end
    init = 1; pulse_disable = 0; trig_n = 1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_pulse_gen.md
MULTI_PULSE_GEN -- requirements
Module: multi_pulse_gen

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 24: sys_clk frequency in MHz; ticks = CLK_MHZ * microseconds.
REQ-002 SHALL have parameter N_CH, default 4: number of output channels, range 1..16.
REQ-003 SHALL have parameter PERIOD_US, default 25_000: pulse-train period; PERIOD_TICKS = CLK_MHZ*PERIOD_US.
REQ-004 SHALL have parameter WIDTH_US, default 50: low-pulse width per channel; WIDTH_TICKS = CLK_MHZ*WIDTH_US, minimum 1.
REQ-005 SHALL have parameter STAGGER_US, default 1_000: channel k start offset = k*STAGGER_TICKS.
REQ-006 SHALL have port sys_clk, input, 1: sole clock.
REQ-007 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port init, input, 1: arm, active-low, pull-up, asynchronous to sys_clk.
REQ-009 SHALL have port pulse_disable, input, 1: active-high stop request, asynchronous.
REQ-010 SHALL have port mode, input, 1: 0 = periodic, 1 = one-shot; sampled only in IDLE.
REQ-011 SHALL have port trig_n, input, 1: one-shot trigger, active-low, asynchronous.
REQ-012 SHALL have port pulse_out, output, N_CH: per-channel pulses, active-low, idle high.
REQ-013 SHALL have port busy, output, 1: high whenever state != IDLE.
REQ-014 SHALL have port period_done, output, 1: one-cycle strobe on the period wrap.

Function
REQ-015 SHALL synchronise init, pulse_disable and trig_n through two flops each; init_s, dis_s, trig_s denote the synchronised values.
REQ-016 SHALL reject at elaboration any configuration where (N_CH-1)*STAGGER_TICKS + WIDTH_TICKS > PERIOD_TICKS.
REQ-017 SHALL use one shared counter cnt of width $clog2(PERIOD_TICKS), counting 0..PERIOD_TICKS-1 while in RUN or STOP.
REQ-018 SHALL drive pulse_out[k] as a register that is low exactly when the state is RUN and cnt lies in [k*STAGGER_TICKS, k*STAGGER_TICKS+WIDTH_TICKS), with one-cycle latency from cnt.
REQ-019 SHALL implement states IDLE, RUN and STOP.
REQ-020 SHALL transition IDLE->RUN with cnt=0 when dis_s=0 and either (mode=0 and init_s=0) or (mode=1 and a falling edge of trig_s occurs).
REQ-021 SHALL, in RUN periodic mode, wrap cnt from PERIOD_TICKS-1 to 0 and pulse period_done for that cycle.
REQ-022 SHALL, in RUN one-shot mode, pulse period_done at cnt=PERIOD_TICKS-1 and go to IDLE.
REQ-023 SHALL transition RUN->STOP when dis_s=1, or when init_s=1 in periodic mode.
REQ-024 SHALL, in STOP, start no new pulse, let any low channel finish its full WIDTH_TICKS, and go to IDLE with cnt=0 once all pulse_out bits are high (no runt pulses).
REQ-025 SHALL ignore trig_s edges outside IDLE and ignore mode changes outside IDLE.
REQ-026 SHALL give latency of exactly 3 sys_clk edges from the first edge sampling init low to pulse_out[0] low (periodic mode, IDLE, dis_s=0).

Reset
REQ-027 SHALL asynchronously force state=IDLE, cnt=0, pulse_out=all ones, busy=0, period_done=0 and synchroniser flops to their idle levels (init/trig_n 1, disable 0) while sys_rst_n=0, including mid-pulse.
REQ-028 SHALL resume only via REQ-020 after reset release, irrespective of input levels during reset.

Structure
REQ-029 SHALL place the state enumeration and the us-to-ticks constant function in shared package pulse_gen_pkg.
REQ-030 SHALL instantiate sub-module sync_2ff, parametrised in width, for all asynchronous inputs.

Verification (CLK_MHZ=1, N_CH=3, PERIOD_US=20, WIDTH_US=3, STAGGER_US=5)
REQ-031 SHALL cover: mode=0, init low -> ch0 low cycles 0-2, ch1 5-7, ch2 10-12 of each 20-cycle period, period_done every 20 cycles.
REQ-032 SHALL cover: pulse_disable high while ch1 is low at cnt=6 -> ch1 stays low through cnt=7, ch2 never falls, busy falls after that pulse, cnt=0.
REQ-033 SHALL cover: mode=1, single trig_n low -> exactly one train (3 pulses), one period_done, return to IDLE; a second trig during RUN is ignored.
REQ-034 SHALL cover: sys_rst_n low at cnt=1 mid-pulse -> pulse_out=3'b111 immediately and busy=0 before the next edge.
REQ-035 SHALL cover: init low and pulse_disable high together -> remains in IDLE, no pulses, busy=0.
